// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W  : width of one arithmetic slice
//   state_t   : controller state encoding (IDLE, RUN, FIN)
//   cnt_width : width of the slice counter for a given slice count
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // The counter must hold 0..nibbles-1; keep at least one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder.
//   START, C_IN, A, B         : request side (master drives)
//   BUSY, DONE, SUM, C_OUT, OVF : status/result side (slave drives)
//
// Handshake: START is a request qualified by BUSY. A request is accepted on a
// rising edge where START=1 and BUSY=0; A, B and C_IN are captured at that
// edge. START while BUSY=1 is dropped, not queued. DONE is a one-cycle pulse
// marking SUM/C_OUT/OVF as the new result; those outputs then hold until the
// next completion.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         START;
  logic         C_IN;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         C_OUT;
  logic         OVF;

  modport master (
    output START, C_IN, A, B,
    input  BUSY, DONE, SUM, C_OUT, OVF
  );

  modport slave (
    input  START, C_IN, A, B,
    output BUSY, DONE, SUM, C_OUT, OVF
  );

endinterface

// File: rtl/nibble_add_slice.sv
// One 4-bit ripple-carry adder slice (purely combinational).
//   a, b : slice operands
//   cin  : carry into bit 0
//   sum  : slice sum
//   cout : carry out of bit 3
module nibble_add_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: adds two W-bit operands one nibble per clock
// through a single nibble_add_slice, carrying between cycles in a register.
//   CLK       : rising-edge clock
//   RST       : synchronous active-high reset (priority over START)
//   bus       : request/result interface (slave side)
//   fsm_state : current controller state, for observation
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  nibble_serial_adder_if.slave  bus,
  output state_t                fsm_state
);

  localparam int             W    = NIBBLE_W * NIBBLES;
  localparam int             CW   = cnt_width(NIBBLES);
  localparam logic [CW-1:0]  LAST = CW'(NIBBLES - 1);

  state_t                state_q, state_d;
  logic                  accept;
  logic [W-1:0]          a_sh, b_sh, psum_q;
  logic                  carry_q;
  logic [CW-1:0]         cnt_q;
  logic                  a_msb_q, b_msb_q;
  logic [W-1:0]          sum_q;
  logic                  c_out_q, ovf_q;

  logic [NIBBLE_W-1:0]   sl_sum;
  logic                  sl_cout;
  logic [W-1:0]          psum_next;
  logic                  ovf_next;

  nibble_add_slice u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Result nibbles enter at the MSB end, so after NIBBLES shifts the first
  // (least significant) nibble has reached bit 0.
  assign psum_next = {sl_sum, psum_q[W-1:NIBBLE_W]};

  // The operand sign bits are shifted out during RUN, so they are kept
  // separately from acceptance for the overflow decision.
  assign ovf_next  = (a_msb_q == b_msb_q) && (psum_next[W-1] != a_msb_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        // A request in the completion cycle starts the next add back-to-back.
        if (bus.START) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh    <= bus.A;
        b_sh    <= bus.B;
        carry_q <= bus.C_IN;
        cnt_q   <= '0;
        a_msb_q <= bus.A[W-1];
        b_msb_q <= bus.B[W-1];
      end else if (state_q == RUN) begin
        a_sh    <= a_sh >> NIBBLE_W;
        b_sh    <= b_sh >> NIBBLE_W;
        psum_q  <= psum_next;
        carry_q <= sl_cout;
        cnt_q   <= cnt_q + CW'(1);
        // Visible results only move on the completing edge.
        if (cnt_q == LAST) begin
          sum_q   <= psum_next;
          c_out_q <= sl_cout;
          ovf_q   <= ovf_next;
        end
      end
    end
  end

  assign bus.BUSY  = (state_q == RUN);
  assign bus.DONE  = (state_q == FIN);
  assign bus.SUM   = sum_q;
  assign bus.C_OUT = c_out_q;
  assign bus.OVF   = ovf_q;
  assign fsm_state = state_q;

endmodule
